// File: rtl/fetch_seq_pkg.sv
// Shared types and reset constants for the instruction-fetch sequencer.
// Imported by fetch_seq; no logic lives here.
package fetch_seq_pkg;

    // Sequencer states; the encoding is fixed so existing debug taps keep decoding it.
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        FLUSH  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam state_t      RST_STATE = FETCH;
    localparam int unsigned RST_INSTR = 0;
    localparam int unsigned RST_REDIR = 0;

endpackage

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: steers the PC register, runs the REQ/ACK memory
// handshake and presents one held instruction at a time to decode.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int IW    = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] PC_IN,
    output logic             PC_EN,
    output logic             PC_INC,
    output logic [WIDTH-1:0] PC_TARGET,
    output logic             MEM_REQ,
    output logic [WIDTH-1:0] MEM_ADDR,
    input  logic             MEM_ACK,
    input  logic [IW-1:0]    MEM_DATA,
    output logic [IW-1:0]    INSTR,
    output logic             INSTR_VALID,
    input  logic             INSTR_READY,
    input  logic             BR_VALID,
    input  logic [WIDTH-1:0] BR_TARGET,
    input  logic             HALT
);

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    instr_q;
    logic [WIDTH-1:0] redir_q;
    logic             capture;
    logic             redir_ld;
    logic             pc_en;
    logic             pc_inc;
    logic [WIDTH-1:0] pc_target;
    logic             after_txn_state_is_halted;

    // Once a transaction retires, HALT decides whether another one starts.
    assign after_txn_state_is_halted = HALT;

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        redir_ld  = 1'b0;
        pc_en     = 1'b0;
        pc_inc    = 1'b0;
        pc_target = '0;
        case (state)
            FETCH: begin
                if (MEM_ACK) begin
                    if (BR_VALID) begin
                        // Redirect lands with the data: drop it and load the PC now.
                        pc_en     = 1'b1;
                        pc_target = BR_TARGET;
                        state_nxt = after_txn_state_is_halted ? HALTED : FETCH;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (BR_VALID) begin
                    redir_ld  = 1'b1;
                    state_nxt = FLUSH;
                end
            end
            HOLD: begin
                if (BR_VALID) begin
                    pc_en     = 1'b1;
                    pc_target = BR_TARGET;
                    state_nxt = after_txn_state_is_halted ? HALTED : FETCH;
                end else if (INSTR_READY) begin
                    pc_en     = 1'b1;
                    pc_inc    = 1'b1;
                    state_nxt = after_txn_state_is_halted ? HALTED : FETCH;
                end
            end
            FLUSH: begin
                // The outstanding request must still complete; its data is discarded.
                // A redirect arriving on the ACK cycle itself is not taken.
                if (MEM_ACK) begin
                    pc_en     = 1'b1;
                    pc_target = redir_q;
                    state_nxt = after_txn_state_is_halted ? HALTED : FETCH;
                end else if (BR_VALID) begin
                    redir_ld = 1'b1;
                end
            end
            HALTED: begin
                if (BR_VALID) begin
                    pc_en     = 1'b1;
                    pc_target = BR_TARGET;
                end
                if (!HALT) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= RST_STATE;
            instr_q <= IW'(RST_INSTR);
            redir_q <= WIDTH'(RST_REDIR);
        end else begin
            state <= state_nxt;
            if (capture) begin
                instr_q <= MEM_DATA;
            end
            if (redir_ld) begin
                redir_q <= BR_TARGET;
            end
        end
    end

    // Reset state is FETCH, so the strobes are gated to stay quiet during reset.
    assign MEM_REQ     = RSTN && ((state == FETCH) || (state == FLUSH));
    assign MEM_ADDR    = PC_IN;
    assign INSTR       = instr_q;
    assign INSTR_VALID = (state == HOLD);
    assign PC_EN       = RSTN && pc_en;
    assign PC_INC      = RSTN && pc_inc;
    assign PC_TARGET   = RSTN ? pc_target : '0;

endmodule

// File: tb/tb_fetch_seq.sv
// Randomized bench for fetch_seq with a transaction-level reference model
// and a behavioural PC register beside the DUT.
module tb_fetch_seq;

    localparam int WIDTH = 6;
    localparam int IW    = 8;

    logic             CLK;
    logic             RSTN;
    logic [WIDTH-1:0] PC_IN;
    logic             PC_EN;
    logic             PC_INC;
    logic [WIDTH-1:0] PC_TARGET;
    logic             MEM_REQ;
    logic [WIDTH-1:0] MEM_ADDR;
    logic             MEM_ACK;
    logic [IW-1:0]    MEM_DATA;
    logic [IW-1:0]    INSTR;
    logic             INSTR_VALID;
    logic             INSTR_READY;
    logic             BR_VALID;
    logic [WIDTH-1:0] BR_TARGET;
    logic             HALT;

    fetch_seq #(.WIDTH(WIDTH), .IW(IW)) dut (
        .CLK(CLK), .RSTN(RSTN), .PC_IN(PC_IN), .PC_EN(PC_EN), .PC_INC(PC_INC),
        .PC_TARGET(PC_TARGET), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
        .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA), .INSTR(INSTR),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
        .BR_VALID(BR_VALID), .BR_TARGET(BR_TARGET), .HALT(HALT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // PC register that sits beside the sequencer in the core.
    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN)      PC_IN <= '0;
        else if (PC_EN) PC_IN <= PC_INC ? PC_IN + 1'b1 : PC_TARGET;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus knobs (percentages).
    int ack_pct, ready_pct, br_pct, halt_flip_pct;
    bit fix_tgt;
    logic [WIDTH-1:0] tgt_val;

    // Reference model: what the fetch pipeline is doing, not how the RTL encodes it.
    bit               m_busy;    // request outstanding on the memory port
    bit               m_disc;    // outstanding request's data is to be thrown away
    bit               m_hold;    // an instruction is waiting for decode
    bit               m_halt;    // fetching stopped
    logic [WIDTH-1:0] m_pc;
    logic [WIDTH-1:0] m_redir;
    logic [IW-1:0]    m_instr;

    task automatic model_reset();
        m_busy = 1; m_disc = 0; m_hold = 0; m_halt = 0;
        m_pc = '0; m_redir = '0; m_instr = '0;
    endtask

    task automatic drive();
        MEM_ACK     = ($urandom_range(99) < ack_pct);
        MEM_DATA    = IW'($urandom);
        INSTR_READY = ($urandom_range(99) < ready_pct);
        BR_VALID    = ($urandom_range(99) < br_pct);
        BR_TARGET   = fix_tgt ? tgt_val : WIDTH'($urandom);
        if ($urandom_range(99) < halt_flip_pct) HALT = ~HALT;
    endtask

    task automatic check_and_step();
        bit               e_en, e_inc;
        logic [WIDTH-1:0] e_tgt;
        e_en = 0; e_inc = 0; e_tgt = '0;
        if (m_hold) begin
            if (BR_VALID)         begin e_en = 1; e_tgt = BR_TARGET; end
            else if (INSTR_READY) begin e_en = 1; e_inc = 1; end
        end else if (m_busy && MEM_ACK) begin
            if (m_disc)           begin e_en = 1; e_tgt = m_redir; end
            else if (BR_VALID)    begin e_en = 1; e_tgt = BR_TARGET; end
        end else if (m_halt && BR_VALID) begin
            e_en = 1; e_tgt = BR_TARGET;
        end

        chk("mem_req",     32'(MEM_REQ),     32'(m_busy));
        chk("instr_valid", 32'(INSTR_VALID), 32'(m_hold));
        chk("instr",       32'(INSTR),       32'(m_instr));
        chk("pc_en",       32'(PC_EN),       32'(e_en));
        chk("pc_inc",      32'(PC_INC),      32'(e_inc));
        chk("pc_target",   32'(PC_TARGET),   32'(e_tgt));
        if (m_busy) chk("mem_addr", 32'(MEM_ADDR), 32'(m_pc));

        // PC is WIDTH bits, so +1 from all-ones wraps to zero.
        if (e_en) m_pc = e_inc ? m_pc + 1'b1 : e_tgt;

        if (m_hold) begin
            if (e_en) begin
                m_hold = 0;
                if (HALT) m_halt = 1; else m_busy = 1;
            end
        end else if (m_busy) begin
            if (MEM_ACK) begin
                if (m_disc || BR_VALID) begin
                    m_disc = 0;
                    if (HALT) begin m_busy = 0; m_halt = 1; end
                end else begin
                    m_busy = 0; m_hold = 1; m_instr = MEM_DATA;
                end
            end else if (BR_VALID) begin
                m_disc = 1; m_redir = BR_TARGET;
            end
        end else if (m_halt && !HALT) begin
            m_halt = 0; m_busy = 1;
        end
    endtask

    // Entered and left at posedge+1: drive, settle, check mid-cycle, advance.
    task automatic cycle();
        drive();
        #3;
        check_and_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_knobs(input int a, input int r, input int b, input int h);
        ack_pct = a; ready_pct = r; br_pct = b; halt_flip_pct = h;
    endtask

    initial begin
        int n;
        logic [WIDTH-1:0] pc_at_halt;
        fix_tgt = 0; tgt_val = '0;
        set_knobs(0, 0, 0, 0);
        RSTN = 0; HALT = 0; MEM_ACK = 0; MEM_DATA = '0;
        INSTR_READY = 0; BR_VALID = 0; BR_TARGET = '0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_req",   32'(MEM_REQ),     0);
        chk("rst_valid", 32'(INSTR_VALID), 0);
        chk("rst_en",    32'(PC_EN),       0);
        chk("rst_instr", 32'(INSTR),       0);
        RSTN = 1;

        // Zero-wait memory, READY high: one instruction per two cycles.
        set_knobs(100, 100, 0, 0);
        for (int c = 1; c <= 8; c++) begin
            if (c % 2 == 1) chk("tput_addr", 32'(MEM_ADDR), 32'((c - 1) / 2));
            cycle();
        end

        // Branch in HOLD with READY low to 63, then consume across the wrap.
        set_knobs(100, 0, 0, 0);
        n = 0;
        while (!m_hold && n < 20) begin cycle(); n++; end
        chk("reach_hold", 32'(m_hold), 1);
        fix_tgt = 1; tgt_val = 6'd63; br_pct = 100;
        cycle();
        br_pct = 0; ready_pct = 100; fix_tgt = 0;
        chk("wrap_addr63", 32'(MEM_ADDR), 63);
        cycle();
        cycle();
        chk("wrap_addr0", 32'(MEM_ADDR), 0);

        // HALT during a pending fetch: instruction still delivered, then stop.
        set_knobs(0, 0, 0, 0);
        HALT = 1;
        cycle(); cycle();
        ack_pct = 100;
        cycle();
        chk("halt_valid", 32'(INSTR_VALID), 1);
        pc_at_halt = MEM_ADDR;
        ack_pct = 0; ready_pct = 100;
        cycle();
        chk("halted_req", 32'(MEM_REQ), 0);
        cycle();
        HALT = 0;
        cycle();
        chk("resume_req",  32'(MEM_REQ), 1);
        chk("resume_addr", 32'(MEM_ADDR), 32'(WIDTH'(pc_at_halt + 1'b1)));

        // Random traffic.
        set_knobs(40, 60, 10, 3);
        for (int i = 0; i < 3000; i++) cycle();
        HALT = 0;

        // Reset while flushing: outputs quiet at once, redirect lost, restart at 0.
        set_knobs(0, 100, 100, 0);
        n = 0;
        while (!m_disc && n < 30) begin cycle(); n++; end
        chk("reach_flush", 32'(m_disc), 1);
        RSTN = 0;
        #1;
        chk("arst_req",   32'(MEM_REQ),     0);
        chk("arst_en",    32'(PC_EN),       0);
        chk("arst_valid", 32'(INSTR_VALID), 0);
        model_reset();
        set_knobs(0, 0, 0, 0);
        @(posedge CLK);
        #1;
        RSTN = 1;
        chk("post_rst_addr", 32'(MEM_ADDR), 0);
        set_knobs(50, 50, 5, 0);
        for (int i = 0; i < 300; i++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
